// File: rtl/systolic_mac_ctrl.sv
// rtl/systolic_mac_ctrl.sv - job sequencer for the weight-stationary MAC systolic array
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, keep_w,      job request (sampled in IDLE), reuse resident weights,
//   num_vec             vector count for the job
//   busy, done          job in flight, one-cycle completion pulse
//   w_rd_en, w_row      weight buffer read strobe and row address
//   w_data              weight row, valid one cycle after w_rd_en
//   x_rd_en, x_idx      feature buffer read strobe and vector index
//   x_data              feature vector, valid one cycle after x_rd_en
//   arr_control         array weight-load line (1 = load)
//   arr_weight          top-row weight_in bus
//   arr_data            left-column data_in bus, slice r feeds row r
//   res_valid           bit c: bottom acc_out of column c holds a result
module systolic_mac_ctrl #(
  parameter int bit_width = 8,
  parameter int depth     = 4,
  parameter int cols      = 4,
  parameter int acc_width = 2*bit_width+depth-1,
  parameter int VEC_W     = 8
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic                                       keep_w,
  input  logic [VEC_W-1:0]                           num_vec,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       w_rd_en,
  output logic [((depth > 1) ? $clog2(depth) : 1)-1:0] w_row,
  input  logic [cols*bit_width-1:0]                  w_data,
  output logic                                       x_rd_en,
  output logic [VEC_W-1:0]                           x_idx,
  input  logic [depth*bit_width-1:0]                 x_data,
  output logic                                       arr_control,
  output logic [cols*bit_width-1:0]                  arr_weight,
  output logic [depth*bit_width-1:0]                 arr_data,
  output logic [cols-1:0]                            res_valid
);

  localparam int ROW_W = (depth > 1) ? $clog2(depth) : 1;
  localparam int DR_W  = $clog2(depth + cols + 1);
  localparam int TOK_W = depth + cols;

  // The accumulator must at least hold one full product.
  if (acc_width < 2*bit_width) begin : g_acc_check
    $error("systolic_mac_ctrl: acc_width narrower than one product");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t            state;
  logic [VEC_W-1:0]  last_idx;
  logic [DR_W-1:0]   drain_cnt;

  // x_vld marks the cycle x_data carries a requested vector.
  logic              x_vld;
  logic [TOK_W-1:0]  tok;

  // ---------------------------------------------------------------------
  // Sequencer. Every strobe is registered here so the buffers see clean
  // flop outputs.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      w_rd_en   <= 1'b0;
      w_row     <= '0;
      x_rd_en   <= 1'b0;
      x_idx     <= '0;
      last_idx  <= '0;
      drain_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            last_idx <= num_vec - 1'b1;
            if (num_vec == '0) begin
              // Empty job: no buffer reads, weights left untouched.
              state <= DONE;
              done  <= 1'b1;
            end else if (keep_w) begin
              state   <= STREAM;
              x_rd_en <= 1'b1;
              x_idx   <= '0;
            end else begin
              // Rows are read bottom-first so that after depth shifts
              // down the array each row holds its own weights.
              state   <= LOAD;
              w_rd_en <= 1'b1;
              w_row   <= ROW_W'(depth - 1);
            end
          end
        end

        LOAD: begin
          if (w_row == '0) begin
            // First feature read overlaps the last control cycle, so
            // vector 0 reaches the array just as control drops.
            state   <= STREAM;
            w_rd_en <= 1'b0;
            x_rd_en <= 1'b1;
            x_idx   <= '0;
          end else begin
            w_row <= w_row - 1'b1;
          end
        end

        STREAM: begin
          if (x_idx == last_idx) begin
            state     <= DRAIN;
            x_rd_en   <= 1'b0;
            x_idx     <= '0;
            // Covers the read latency, skew, array depth and column walk
            // of the last vector.
            drain_cnt <= DR_W'(depth + cols);
          end else begin
            x_idx <= x_idx + 1'b1;
          end
        end

        DRAIN: begin
          if (drain_cnt == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Control delay, data-valid flag and result token chain. Token bit k is
  // a vector's valid delayed k+1 cycles past its x_data cycle; the bottom
  // row of column c emits that vector depth+1+c cycles after x_data.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr_control <= 1'b0;
      x_vld       <= 1'b0;
      tok         <= '0;
    end else begin
      arr_control <= w_rd_en;
      x_vld       <= x_rd_en;
      tok         <= {tok[TOK_W-2:0], x_vld};
    end
  end

  assign res_valid  = tok[TOK_W-1 -: cols];
  assign arr_weight = arr_control ? w_data : '0;

  // ---------------------------------------------------------------------
  // Input skew. Row 0 passes straight through; row r goes through r
  // registers. Gating at the entry keeps non-vector slots at zero.
  // ---------------------------------------------------------------------
  assign arr_data[0 +: bit_width] = x_vld ? x_data[0 +: bit_width] : '0;

  for (genvar r = 1; r < depth; r++) begin : g_skew
    logic [bit_width-1:0] sk [r];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < r; k++) begin
          sk[k] <= '0;
        end
      end else begin
        sk[0] <= x_vld ? x_data[r*bit_width +: bit_width] : '0;
        for (int k = 1; k < r; k++) begin
          sk[k] <= sk[k-1];
        end
      end
    end

    assign arr_data[r*bit_width +: bit_width] = sk[r-1];
  end

endmodule

// File: tb/tb_systolic_mac_ctrl.sv
// tb/tb_systolic_mac_ctrl.sv - self-checking bench for systolic_mac_ctrl with buffer and MAC array models
module tb_systolic_mac_ctrl;

  localparam int BW  = 8;
  localparam int D   = 4;
  localparam int C   = 4;
  localparam int ACC = 2*BW + D - 1;
  localparam int VW  = 8;
  localparam int RW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              keep_w = 1'b0;
  logic [VW-1:0]     num_vec = '0;
  logic              busy, done, w_rd_en, x_rd_en, arr_control;
  logic [RW-1:0]     w_row;
  logic [VW-1:0]     x_idx;
  logic [C*BW-1:0]   w_data = '0;
  logic [C*BW-1:0]   arr_weight;
  logic [D*BW-1:0]   x_data = '0;
  logic [D*BW-1:0]   arr_data;
  logic [C-1:0]      res_valid;

  int checks = 0;
  int errors = 0;
  int cur_t  = 0;
  bit res_ok = 1'b0;

  always #5 clk = ~clk;

  systolic_mac_ctrl #(
    .bit_width (BW),
    .depth     (D),
    .cols      (C),
    .acc_width (ACC),
    .VEC_W     (VW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .keep_w      (keep_w),
    .num_vec     (num_vec),
    .busy        (busy),
    .done        (done),
    .w_rd_en     (w_rd_en),
    .w_row       (w_row),
    .w_data      (w_data),
    .x_rd_en     (x_rd_en),
    .x_idx       (x_idx),
    .x_data      (x_data),
    .arr_control (arr_control),
    .arr_weight  (arr_weight),
    .arr_data    (arr_data),
    .res_valid   (res_valid)
  );

  // Buffers: registered read, junk on the bus when not reading.
  logic [C*BW-1:0] wmem  [D];
  logic [D*BW-1:0] feat  [256];
  logic [C*BW-1:0] res_w [D];

  always @(posedge clk) begin
    w_data <= w_rd_en ? wmem[w_row] : $urandom;
    x_data <= x_rd_en ? feat[x_idx] : $urandom;
  end

  // Weight-stationary MAC array; bottom row output is registered once more.
  logic [BW-1:0]  mw   [D][C];
  logic [BW-1:0]  md   [D][C];
  logic [ACC-1:0] macc [D][C];
  logic [ACC-1:0] bottom [C];
  logic [BW-1:0]  t_din;
  logic [ACC-1:0] t_ain;

  always @(posedge clk) begin
    for (int r = 0; r < D; r++) begin
      for (int c = 0; c < C; c++) begin
        if (c == 0) t_din = arr_data[r*BW +: BW];
        else        t_din = md[r][c-1];
        if (r == 0) t_ain = '0;
        else        t_ain = macc[r-1][c];
        md[r][c] <= t_din;
        if (arr_control) begin
          if (r == 0) mw[r][c] <= arr_weight[c*BW +: BW];
          else        mw[r][c] <= mw[r-1][c];
          macc[r][c] <= '0;
        end else begin
          macc[r][c] <= t_ain + ACC'(mw[r][c]) * ACC'(t_din);
        end
      end
    end
    for (int c = 0; c < C; c++) bottom[c] <= macc[D-1][c];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%0h want=%0h", nm, cur_t, act, exp);
    end
  endtask

  function automatic int dot(input int v, input int c);
    int s = 0;
    for (int r = 0; r < D; r++)
      s += int'(res_w[r][c*BW +: BW]) * int'(feat[v][r*BW +: BW]);
    return s;
  endfunction

  task automatic fill(input int wm, input int xm);
    for (int r = 0; r < D; r++)
      for (int c = 0; c < C; c++)
        case (wm)
          0:       wmem[r][c*BW +: BW] = (r == c) ? 8'd1 : 8'd0;
          1:       wmem[r][c*BW +: BW] = 8'd2;
          2:       wmem[r][c*BW +: BW] = 8'd255;
          default: wmem[r][c*BW +: BW] = 8'($urandom_range(0, 255));
        endcase
    for (int v = 0; v < 256; v++)
      for (int r = 0; r < D; r++)
        case (xm)
          0:       feat[v][r*BW +: BW] = 8'(r + 1);
          1:       feat[v][r*BW +: BW] = 8'(v + 1);
          2:       feat[v][r*BW +: BW] = 8'd255;
          default: feat[v][r*BW +: BW] = 8'($urandom_range(0, 255));
        endcase
  endtask

  // One job, checked cycle by cycle against closed-form expectations.
  // Cycle t is the interval after the t-th rising edge from the start cycle.
  task automatic run_job(input bit kw, input int n, input int restart_t,
                         input int abort_t, input bit chain,
                         input int exp_done, input int exp_first);
    int  fx, s, dn, t_end, t_done, t_first, v;
    bit  load;
    logic [D*BW-1:0] e_ad;
    logic [C*BW-1:0] e_aw;
    logic [C-1:0]    e_rv;
    load = !kw && (n != 0);
    if (load) begin
      res_w  = wmem;
      res_ok = 1'b1;
    end
    fx      = kw ? 1 : D + 1;
    s       = fx + 1;
    dn      = (n == 0) ? 1 : s + n + D + C;
    t_end   = (abort_t >= 0) ? abort_t : (chain ? dn : dn + 2);
    t_done  = -1;
    t_first = -1;
    for (int t = 0; t <= t_end; t++) begin
      @(negedge clk);
      cur_t = t;
      if (t == abort_t) begin
        rst_n = 1'b0;
        #1;
        chk("abort_ctrl", {busy, done, w_rd_en, w_row, x_rd_en, x_idx, arr_control, res_valid}, '0);
        chk("abort_data", {arr_weight, arr_data}, '0);
        res_ok = 1'b0;
        start  = 1'b0;
        return;
      end
      if (done) t_done = t;
      if (res_valid != '0 && t_first < 0) t_first = t;

      chk("busy", busy, (t >= 1 && t <= dn));
      chk("done", done, (t == dn));
      chk("w_rd_en", w_rd_en, (load && t >= 1 && t <= D));
      if (load && t >= 1 && t <= D) chk("w_row", w_row, D - t);
      chk("arr_control", arr_control, (load && t >= 2 && t <= D + 1));
      e_aw = (load && t >= 2 && t <= D + 1) ? wmem[D - t + 1] : '0;
      chk("arr_weight", arr_weight, e_aw);
      chk("x_rd_en", x_rd_en, (n != 0 && t >= fx && t < fx + n));
      if (n != 0 && t >= fx && t < fx + n) chk("x_idx", x_idx, t - fx);
      for (int r = 0; r < D; r++) begin
        v = t - s - r;
        e_ad[r*BW +: BW] = (n != 0 && v >= 0 && v < n) ? feat[v][r*BW +: BW] : 8'd0;
      end
      chk("arr_data", arr_data, e_ad);
      for (int c = 0; c < C; c++) begin
        v = t - s - D - 1 - c;
        e_rv[c] = (n != 0 && v >= 0 && v < n);
      end
      chk("res_valid", res_valid, e_rv);
      for (int c = 0; c < C; c++) begin
        v = t - s - D - 1 - c;
        if (e_rv[c] && res_valid[c]) chk("acc_out", bottom[c], dot(v, c));
      end

      start   = (t == 0) || (t == restart_t);
      keep_w  = (t == 0) ? kw : 1'($urandom);
      num_vec = (t == 0) ? VW'(n) : VW'($urandom);
    end
    if (exp_done != -2)  chk("done_cycle", t_done, exp_done);
    if (exp_first != -2) chk("first_result_cycle", t_first, exp_first);
  endtask

  typedef struct {
    bit kw;
    int n;
    int wm;
    int xm;
    int restart_t;
    int exp_done;
    int exp_first;
  } job_t;

  job_t jobs [8];

  initial begin
    jobs[0] = '{kw: 0, n: 1,   wm: 0, xm: 0, restart_t: -1, exp_done: 15,  exp_first: 11};
    jobs[1] = '{kw: 0, n: 3,   wm: 1, xm: 1, restart_t: -1, exp_done: 17,  exp_first: 11};
    jobs[2] = '{kw: 0, n: 0,   wm: 3, xm: 3, restart_t: -1, exp_done: 1,   exp_first: -1};
    jobs[3] = '{kw: 1, n: 3,   wm: 3, xm: 1, restart_t: -1, exp_done: 13,  exp_first: 7};
    jobs[4] = '{kw: 1, n: 0,   wm: 3, xm: 3, restart_t: -1, exp_done: 1,   exp_first: -1};
    jobs[5] = '{kw: 0, n: 4,   wm: 2, xm: 2, restart_t: 7,  exp_done: 18,  exp_first: 11};
    jobs[6] = '{kw: 1, n: 2,   wm: 3, xm: 3, restart_t: 2,  exp_done: 12,  exp_first: 7};
    jobs[7] = '{kw: 1, n: 255, wm: 3, xm: 3, restart_t: 40, exp_done: 265, exp_first: 7};

    fill(0, 0);
    repeat (3) @(negedge clk);
    cur_t = -1;
    chk("reset_ctrl", {busy, done, w_rd_en, w_row, x_rd_en, x_idx, arr_control, res_valid}, '0);
    chk("reset_data", {arr_weight, arr_data}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      fill(jobs[i].wm, jobs[i].xm);
      run_job(jobs[i].kw, jobs[i].n, jobs[i].restart_t, -1, 1'b0,
              jobs[i].exp_done, jobs[i].exp_first);
    end

    for (int i = 0; i < 8; i++) begin
      bit kw;
      kw = res_ok ? 1'($urandom_range(0, 1)) : 1'b0;
      fill(3, 3);
      run_job(kw, $urandom_range(0, 12), -1, -1, 1'($urandom_range(0, 1)), -2, -2);
    end

    // Reset while draining, then a fresh job must load and run cleanly.
    fill(3, 3);
    run_job(1'b0, 3, -1, 10, 1'b0, -2, -2);
    @(negedge clk);
    rst_n = 1'b1;
    fill(1, 3);
    run_job(1'b0, 5, -1, -1, 1'b0, 6 + 5 + D + C, 11);

    // Back-to-back: next start in the cycle right after done.
    fill(3, 3);
    run_job(1'b0, 2, -1, -1, 1'b1, 16, 11);
    fill(3, 3);
    run_job(1'b1, 3, -1, -1, 1'b0, 13, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
